// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the 5-stage pipeline control path:
//   - state_e      : hazard controller FSM state encoding (RUN, MD_WAIT)
//   - REG_ADDR_W   : architectural register index width
//   - X0_IDX       : index of the hard-wired zero register
//   - bubble_t     : fields of an ID/EX entry that a flush forces to zero
//   - BUBBLE       : the bubble encoding loaded by a flushed pipeline register
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  alusrc;
        logic [31:0]           data;
    } bubble_t;

    // A flushed pipeline register holds an all-zero entry writing x0: a no-op.
    localparam bubble_t BUBBLE = '{rd: X0_IDX, alusrc: 1'b0, data: 32'd0};

endpackage : pipe_pkg

// File: rtl/hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter used for pipeline performance statistics. Counts one
// per clock while inc_i is high and sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low clear
//   inc_i  in   count enable for this cycle
//   cnt_o  out  current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: the next-state value gets a default before any condition so the
    // combinational block can never infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Sequencing controller for the 5-stage core. Produces load enables and flush
// controls for PC, IF/ID and ID/EX. Handles, in priority order:
//   taken branch  -> squash IF/ID and ID/EX in one cycle, PC redirects
//   mul/div in EX -> launch the unit, freeze the front end until md_done
//                    (or a timeout, which raises the sticky md_error)
//   load-use      -> hold PC and IF/ID for one cycle, bubble into ID/EX
// Outputs are Mealy: state plus current inputs.
//
// Ports:
//   clock, reset_n                    clock and async active-low reset
//   id_valid, id_rs1, id_rs2,
//   id_uses_rs1, id_uses_rs2          ID-stage source operand info
//   ex_valid, ex_rd, ex_mem_read,
//   ex_branch_taken, ex_md_req        EX-stage instruction info
//   md_done                           mul/div completion pulse
//   md_start                          mul/div launch pulse
//   pc_en, if_id_en, id_ex_en         register load enables
//   if_id_flush, id_ex_flush          load bubble (overrides enable)
//   md_error                          sticky mul/div timeout flag
//   stall_cnt, flush_cnt              saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16,
    parameter int MD_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,

    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_md_req,

    input  logic                  md_done,
    output logic                  md_start,

    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,

    output logic                  md_error,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int TMO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             md_error_q, md_error_d;

    // Raw FSM outputs before the reset override.
    logic pc_en_c, if_id_en_c, id_ex_en_c;
    logic if_id_flush_c, id_ex_flush_c, md_start_c;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic branch_hit;
    logic md_hit;
    logic rs1_dep, rs2_dep;
    logic load_use_hit;
    logic tmo_hit;

    assign branch_hit = ex_valid && ex_branch_taken;
    assign md_hit     = ex_valid && ex_md_req;

    assign rs1_dep = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_dep = id_uses_rs2 && (id_rs2 == ex_rd);

    assign load_use_hit = ex_valid && ex_mem_read
                       && (ex_rd != REG_ADDR_W'(X0_IDX))
                       && id_valid && (rs1_dep || rs2_dep);

    assign tmo_hit = (tmo_q == TMO_LAST);

    // -------------------------------------------------------------------------
    // FSM next-state and Mealy outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        md_error_d    = md_error_q;
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        id_ex_en_c    = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        md_start_c    = 1'b0;

        unique case (state_q)
            RUN: begin
                // md_done is meaningless here; the unit is idle.
                if (branch_hit) begin
                    // Both younger slots are wrong-path: squash them together.
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (md_hit) begin
                    md_start_c = 1'b1;
                    pc_en_c    = 1'b0;
                    if_id_en_c = 1'b0;
                    id_ex_en_c = 1'b0;
                    tmo_d      = '0;
                    state_d    = MD_WAIT;
                end else if (load_use_hit) begin
                    // Hold the consumer in ID; the load moves to MEM and its
                    // data becomes forwardable next cycle.
                    pc_en_c       = 1'b0;
                    if_id_en_c    = 1'b0;
                    id_ex_flush_c = 1'b1;
                end
            end

            MD_WAIT: begin
                // Branch/load-use terms are irrelevant: the front end is frozen
                // behind the mul/div, and a still-high ex_md_req on the release
                // cycle belongs to the instruction that just completed.
                if (md_done || tmo_hit) begin
                    state_d = RUN;
                    if (!md_done) begin
                        md_error_d = 1'b1;
                    end
                end else begin
                    pc_en_c    = 1'b0;
                    if_id_en_c = 1'b0;
                    id_ex_en_c = 1'b0;
                    tmo_d      = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            tmo_q      <= '0;
            md_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            md_error_q <= md_error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: while reset is held the pipeline registers are kept loading
    // bubbles and nothing advances, independent of the clock.
    // -------------------------------------------------------------------------
    assign pc_en       = reset_n && pc_en_c;
    assign if_id_en    = reset_n && if_id_en_c;
    assign id_ex_en    = reset_n && id_ex_en_c;
    assign if_id_flush = !reset_n || if_id_flush_c;
    assign id_ex_flush = !reset_n || id_ex_flush_c;
    assign md_start    = reset_n && md_start_c;
    assign md_error    = md_error_q;

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .inc_i (!pc_en),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .inc_i (id_ex_flush),
        .cnt_o (flush_cnt)
    );

endmodule : hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Generates the enable and flush controls for the PC, IF/ID and ID/EX pipeline registers. It resolves load-use hazards (one bubble) and taken branches (two-stage flush), and freezes the front end while a multi-cycle mul/div unit in EX completes via a start/done handshake. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- CNT_W, 16, performance counter width
- MD_TIMEOUT, 64, maximum MD_WAIT cycles before forced release

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  REG_ADDR_W  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX branch/jump resolved taken
- ex_md_req  in  1  EX instruction is mul/div
- md_done  in  1  mul/div result ready, 1-cycle pulse
- md_start  out  1  1-cycle launch pulse to mul/div unit
- pc_en, if_id_en, id_ex_en  out  1  register load enables
- if_id_flush, id_ex_flush  out  1  load bubble (all-zero, rd=0); flush overrides enable at the pipeline register
- md_error  out  1  sticky: an MD timeout occurred
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- FSM states: RUN, MD_WAIT. Outputs are Mealy, derived from the state plus the current inputs.
- Evaluation priority in RUN: branch > md > load-use > normal.
- Branch: ex_valid && ex_branch_taken. Drives pc_en=1, if_id_flush=1, id_ex_flush=1 and if_id_en=id_ex_en=1. Stays in RUN.
- Md: ex_valid && ex_md_req. Drives md_start=1 and pc_en=if_id_en=id_ex_en=0, with no flush. Next state is MD_WAIT and the timeout counter clears.
- Load-use: ex_valid && ex_mem_read && ex_rd!=0 && id_valid && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). Drives pc_en=if_id_en=0, id_ex_en=1, id_ex_flush=1. Stays in RUN; the hazard clears the next cycle when the load reaches MEM.
- Normal: all enables 1, all flushes 0.
- MD_WAIT with md_done=0: all enables 0, flushes 0, md_start=0. The timeout counter increments.
- MD_WAIT with md_done=1, or timeout counter == MD_TIMEOUT-1: all enables 1 for this cycle (release), then RUN. A timeout-caused release also sets md_error.
- In MD_WAIT, ex_branch_taken and the load-use terms are ignored. ex_md_req still high in the release cycle does not relaunch.
- md_done is ignored in RUN.
- stall_cnt increments on every cycle with pc_en=0.
- flush_cnt increments on every cycle with id_ex_flush=1.
- Both counters saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=RUN; stall_cnt=0, flush_cnt=0, md_error=0, timeout counter=0.
  - Outputs forced: pc_en=if_id_en=id_ex_en=0, if_id_flush=id_ex_flush=1, md_start=0.
- First edge after reset release: normal RUN evaluation.
- Load-use costs exactly 1 stall cycle. Taken branch costs 2 squashed slots in a single flush cycle.
- Md: md_start at cycle T with the freeze starting at T. If md_done arrives at T+k (k≥1), the release is at T+k and RUN resumes at T+k+1. Total frozen cycles = k.
- Timeout with no md_done: release at T+MD_TIMEOUT.
- Reset asserted in MD_WAIT: abort immediately to RUN. The mul/div unit must also be reset by the same reset_n.
- Counter and state updates occur on the rising clock edge only.

## Structure
- Shared package pipe_pkg: state enum {RUN, MD_WAIT}, REG_ADDR_W, the bubble encoding constant (rd=0, alusrc=0, data=0), and the x0 index constant.
- Sub-module sat_counter #(W): inc input, saturating, async active-low clear. Instantiated twice (stall_cnt, flush_cnt).
- Hazard compare logic is inline combinational; FSM and timeout counter live in hazard_ctrl.

## Test plan
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs2=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal; stall_cnt=1, flush_cnt=1.
- Same, but ex_rd=0 or id_uses_rs2=0 -> no stall; all enables 1.
- ex_branch_taken=1 and load-use both true -> branch wins: if_id_flush=id_ex_flush=1, pc_en=1; stall_cnt unchanged.
- ex_md_req=1 at T, md_done at T+4 -> md_start pulse only at T; enables 0 for T..T+3, 1 at T+4; stall_cnt=4.
- ex_md_req=1, md_done never arrives, MD_TIMEOUT=8 -> release at T+8, md_error=1 and held. Then assert reset_n=0 mid-MD_WAIT on a later request -> immediate flush outputs, md_error=0, counters 0.
- Hold a stall condition for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt saturates at 15.
